// File: rtl/fll_pkg.sv
// Shared helpers for the fll FIFO family.
package fll_pkg;

  // Width of an occupancy counter able to hold the values 0..n.
  function automatic int fll_cw(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fll_fifo_if.sv
// vld/rdy handshake bundle for the fll FIFO input and output ports.
interface fll_fifo_if #(
  parameter int DW = 8
);
  logic [DW-1:0] ffi_bus;
  logic          ffi_vld;
  logic          ffi_rdy;
  logic [DW-1:0] ffo_bus;
  logic          ffo_vld;
  logic          ffo_rdy;

  // Producer and consumer side (drives input data, accepts output data).
  modport master (
    output ffi_bus, ffi_vld, ffo_rdy,
    input  ffi_rdy, ffo_bus, ffo_vld
  );

  // FIFO side.
  modport slave (
    input  ffi_bus, ffi_vld, ffo_rdy,
    output ffi_rdy, ffo_bus, ffo_vld
  );
endinterface

// File: rtl/fll_mem.sv
// FF x DW storage: one synchronous write port, one asynchronous read port.
// Contents are not reset; validity is tracked by the FIFO control logic.
module fll_mem #(
  parameter int DW = 8,
  parameter int FF = 4,
  parameter int PW = 2
) (
  input  logic          ff_clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [PW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [FF];

  // Write port: store the pushed word at the write pointer.
  always_ff @(posedge ff_clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fll_fifo.sv
// Single-clock FIFO of any depth with optional registered output stage,
// occupancy count, runtime thresholds, synchronous flush and peak watermark.
module fll_fifo
  import fll_pkg::*;
#(
  parameter  int DW  = 8,
  parameter  int FF  = 4,
  parameter  int RO  = 0,
  localparam int CAP = FF + RO,
  localparam int CW  = fll_cw(CAP)
) (
  input  logic          ff_clk,
  input  logic          ff_rst,
  input  logic          ff_clr,
  fll_fifo_if.slave     ff_if,
  input  logic [CW-1:0] ff_thf,
  input  logic [CW-1:0] ff_the,
  output logic [CW-1:0] ff_cnt,
  output logic          ff_alf,
  output logic          ff_ale,
  output logic [CW-1:0] ff_max
);

  localparam int            PW       = (FF > 1) ? $clog2(FF) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(FF - 1);
  localparam logic [CW-1:0] CAP_C    = CW'(CAP);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] max_q, max_d;
  logic          rdy_q, rdy_d;
  logic          push_s, pop_s, vld_s;
  logic          mem_we_s, rd_adv_s;
  logic [DW-1:0] mem_rdata_s;

  // Flush masks both handshakes so no transfer happens in a flush cycle.
  assign ff_if.ffi_rdy = rdy_q & ~ff_clr;
  assign ff_if.ffo_vld = vld_s & ~ff_clr;
  assign push_s        = ff_if.ffi_vld & ff_if.ffi_rdy;
  assign pop_s         = ff_if.ffo_vld & ff_if.ffo_rdy;

  // Occupancy, ready and watermark next-state; ready only looks at the count,
  // so a full FIFO refuses a push even while it is being popped.
  always_comb begin
    cnt_d = cnt_q;
    if (ff_clr) begin
      cnt_d = {CW{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
    rdy_d = (cnt_d < CAP_C);
    if (ff_clr) begin
      max_d = {CW{1'b0}};
    end else if (cnt_d > max_q) begin
      max_d = cnt_d;
    end else begin
      max_d = max_q;
    end
  end

  // Memory pointers wrap at FF-1, which need not be a power of two.
  always_comb begin
    if (ff_clr) begin
      wr_ptr_d = {PW{1'b0}};
    end else if (mem_we_s) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? {PW{1'b0}} : wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (ff_clr) begin
      rd_ptr_d = {PW{1'b0}};
    end else if (rd_adv_s) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? {PW{1'b0}} : rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Control state registers.
  always_ff @(posedge ff_clk or negedge ff_rst) begin
    if (!ff_rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      cnt_q    <= {CW{1'b0}};
      max_q    <= {CW{1'b0}};
      rdy_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      max_q    <= max_d;
      rdy_q    <= rdy_d;
    end
  end

  assign ff_cnt = cnt_q;
  assign ff_max = max_q;
  assign ff_alf = (cnt_q >= ff_thf);
  assign ff_ale = (cnt_q <= ff_the);

  fll_mem #(
    .DW(DW),
    .FF(FF),
    .PW(PW)
  ) u_mem (
    .ff_clk(ff_clk),
    .we    (mem_we_s),
    .waddr (wr_ptr_q),
    .wdata (ff_if.ffi_bus),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata_s)
  );

  if (RO == 0) begin : g_comb_out
    // Head word comes straight from memory; every push and pop uses it.
    assign vld_s         = (cnt_q != {CW{1'b0}});
    assign ff_if.ffo_bus = mem_rdata_s;
    assign mem_we_s      = push_s;
    assign rd_adv_s      = pop_s;
  end else begin : g_reg_out
    logic [DW-1:0] obus_q, obus_d;
    logic          ovld_q, ovld_d;
    logic [CW-1:0] mcnt_s;
    logic          bypass_s;

    // Head register: a push goes straight in when nothing else would be ahead
    // of it, otherwise a pop refills the head from memory.
    always_comb begin
      mcnt_s   = cnt_q - CW'(ovld_q);
      bypass_s = push_s & (~ovld_q | (pop_s & (mcnt_s == {CW{1'b0}})));
      mem_we_s = push_s & ~bypass_s;
      rd_adv_s = pop_s & (mcnt_s != {CW{1'b0}});
      obus_d   = obus_q;
      ovld_d   = ovld_q;
      if (ff_clr) begin
        ovld_d = 1'b0;
      end else if (bypass_s) begin
        obus_d = ff_if.ffi_bus;
        ovld_d = 1'b1;
      end else if (pop_s) begin
        if (mcnt_s != {CW{1'b0}}) begin
          obus_d = mem_rdata_s;
          ovld_d = 1'b1;
        end else begin
          ovld_d = 1'b0;
        end
      end else begin
        ovld_d = ovld_q;
      end
    end

    // Output stage registers.
    always_ff @(posedge ff_clk or negedge ff_rst) begin
      if (!ff_rst) begin
        obus_q <= {DW{1'b0}};
        ovld_q <= 1'b0;
      end else begin
        obus_q <= obus_d;
        ovld_q <= ovld_d;
      end
    end

    assign vld_s         = ovld_q;
    assign ff_if.ffo_bus = obus_q;
  end

endmodule

// File: tb/tb_fll_fifo.sv
// Bench for fll_fifo: drives a FF=5/RO=0 and a FF=3/RO=1 instance with the
// same stimulus and checks each against its own queue-based reference.
module tb_fll_fifo;
  localparam int DW    = 8;
  localparam int CW    = 3;
  localparam int CAP_A = 5;
  localparam int CAP_B = 4;

  logic          ff_clk, ff_rst, ff_clr;
  logic [CW-1:0] ff_thf, ff_the;
  logic [CW-1:0] cnt_a, max_a, cnt_b, max_b;
  logic          alf_a, ale_a, alf_b, ale_b;

  fll_fifo_if #(.DW(DW)) ifa ();
  fll_fifo_if #(.DW(DW)) ifb ();

  fll_fifo #(.DW(DW), .FF(5), .RO(0)) dut_a (
    .ff_clk(ff_clk), .ff_rst(ff_rst), .ff_clr(ff_clr), .ff_if(ifa.slave),
    .ff_thf(ff_thf), .ff_the(ff_the), .ff_cnt(cnt_a), .ff_alf(alf_a),
    .ff_ale(ale_a), .ff_max(max_a)
  );

  fll_fifo #(.DW(DW), .FF(3), .RO(1)) dut_b (
    .ff_clk(ff_clk), .ff_rst(ff_rst), .ff_clr(ff_clr), .ff_if(ifb.slave),
    .ff_thf(ff_thf), .ff_the(ff_the), .ff_cnt(cnt_b), .ff_alf(alf_b),
    .ff_ale(ale_b), .ff_max(max_b)
  );

  initial ff_clk = 1'b0;
  always #5 ff_clk = ~ff_clk;

  // Reference state: contents as plain queues, plus ready and peak.
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  bit         rdy_ma, rdy_mb;
  int         max_ma, max_mb;
  bit         acc_a, pop_a;
  logic [7:0] obus_a, obus_b;
  logic       ovld_a, ovld_b, ordy_a;
  logic [CW-1:0] ocnt_a, omax_a;
  int         vectors = 0;
  int         miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_port(input string nm, input int qsize, input logic [7:0] qhead,
                          input bit rdy_m, input int max_m, input logic o_rdy,
                          input logic o_vld, input logic [7:0] o_bus,
                          input logic [CW-1:0] o_cnt, input logic o_alf,
                          input logic o_ale, input logic [CW-1:0] o_max);
    bit exp_vld;
    exp_vld = (qsize > 0) && !ff_clr;
    chk({nm, "_rdy"}, 32'(o_rdy), 32'(rdy_m && !ff_clr));
    chk({nm, "_vld"}, 32'(o_vld), 32'(exp_vld));
    if (exp_vld) chk({nm, "_bus"}, 32'(o_bus), 32'(qhead));
    chk({nm, "_cnt"}, 32'(o_cnt), 32'(qsize));
    chk({nm, "_alf"}, 32'(o_alf), 32'(qsize >= int'(ff_thf)));
    chk({nm, "_ale"}, 32'(o_ale), 32'(qsize <= int'(ff_the)));
    chk({nm, "_max"}, 32'(o_max), 32'(max_m));
  endtask

  // One clock cycle: drive at the falling edge, check just after, then let
  // the rising edge happen and advance the reference.
  task automatic step(input bit rst, input bit clr, input bit vld,
                      input logic [7:0] d, input bit ordy);
    bit         acc_b, pop_b;
    logic [7:0] tmp;
    @(negedge ff_clk);
    ff_rst = rst;
    ff_clr = clr;
    ifa.ffi_vld = vld; ifa.ffi_bus = d; ifa.ffo_rdy = ordy;
    ifb.ffi_vld = vld; ifb.ffi_bus = d; ifb.ffo_rdy = ordy;
    if (!rst) begin
      qa.delete(); qb.delete();
      rdy_ma = 1'b0; rdy_mb = 1'b0; max_ma = 0; max_mb = 0;
    end
    #1;
    chk_port("a", qa.size(), (qa.size() > 0) ? qa[0] : 8'h00, rdy_ma, max_ma,
             ifa.ffi_rdy, ifa.ffo_vld, ifa.ffo_bus, cnt_a, alf_a, ale_a, max_a);
    chk_port("b", qb.size(), (qb.size() > 0) ? qb[0] : 8'h00, rdy_mb, max_mb,
             ifb.ffi_rdy, ifb.ffo_vld, ifb.ffo_bus, cnt_b, alf_b, ale_b, max_b);
    if (!rst) chk("b_rst_bus", 32'(ifb.ffo_bus), 32'(0));
    obus_a = ifa.ffo_bus; obus_b = ifb.ffo_bus;
    ovld_a = ifa.ffo_vld; ovld_b = ifb.ffo_vld;
    ordy_a = ifa.ffi_rdy; ocnt_a = cnt_a; omax_a = max_a;
    acc_a = rst && !clr && vld && rdy_ma;
    pop_a = rst && !clr && ordy && (qa.size() > 0);
    acc_b = rst && !clr && vld && rdy_mb;
    pop_b = rst && !clr && ordy && (qb.size() > 0);
    @(posedge ff_clk);
    if (rst) begin
      if (clr) begin
        qa.delete(); qb.delete();
        max_ma = 0; max_mb = 0; rdy_ma = 1'b1; rdy_mb = 1'b1;
      end else begin
        if (pop_a) tmp = qa.pop_front();
        if (acc_a) qa.push_back(d);
        rdy_ma = (qa.size() < CAP_A);
        if (qa.size() > max_ma) max_ma = qa.size();
        if (pop_b) tmp = qb.pop_front();
        if (acc_b) qb.push_back(d);
        rdy_mb = (qb.size() < CAP_B);
        if (qb.size() > max_mb) max_mb = qb.size();
      end
    end
  endtask

  initial begin
    int v;
    int k;
    int guard;
    ff_rst = 1'b0; ff_clr = 1'b0; ff_thf = 3'd3; ff_the = 3'd1;
    ifa.ffi_vld = 1'b0; ifa.ffi_bus = 8'h00; ifa.ffo_rdy = 1'b0;
    ifb.ffi_vld = 1'b0; ifb.ffi_bus = 8'h00; ifb.ffo_rdy = 1'b0;

    // Reset, then release and push 0x01..0x05 back to back.
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    v = 1;
    guard = 0;
    step(1'b1, 1'b0, 1'b1, 8'(v), 1'b0);
    chk("first_cycle_rdy", 32'(ordy_a), 32'(0));
    while (v <= 5 && guard < 20) begin
      step(1'b1, 1'b0, 1'b1, 8'(v), 1'b0);
      if (acc_a) v++;
      guard++;
    end
    chk("fill_pushes", 32'(v), 32'(6));
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("fill_cnt", 32'(ocnt_a), 32'(5));
    chk("fill_rdy", 32'(ordy_a), 32'(0));

    // Drain: words come back in push order.
    k = 1;
    guard = 0;
    while (qa.size() > 0 && guard < 20) begin
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      if (pop_a) begin
        chk("drain_order", 32'(obus_a), 32'(k));
        k++;
      end
      guard++;
    end
    chk("drain_words", 32'(k), 32'(6));
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("drain_max", 32'(omax_a), 32'(5));

    // Simultaneous push and pop with two entries held.
    step(1'b1, 1'b0, 1'b1, 8'h10, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'h11, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b1, 8'(8'h20 + i), 1'b1);
      chk("pp_cnt", 32'(ocnt_a), 32'(2));
    end

    // Full with push and pop together: only the pop completes.
    guard = 0;
    while (qa.size() < CAP_A && guard < 20) begin
      step(1'b1, 1'b0, 1'b1, 8'(8'h40 + guard), 1'b0);
      guard++;
    end
    step(1'b1, 1'b0, 1'b1, 8'h66, 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("full_pp_cnt", 32'(ocnt_a), 32'(CAP_A - 1));

    // Flush at count 3 together with push and pop requests.
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b1, 1'b1, 8'h55, 1'b1);
    chk("flush_no_pop", 32'(ovld_a), 32'(0));
    chk("flush_no_push", 32'(ordy_a), 32'(0));
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("flush_cnt", 32'(ocnt_a), 32'(0));
    chk("flush_vld", 32'(ovld_a), 32'(0));
    chk("flush_max", 32'(omax_a), 32'(0));
    step(1'b1, 1'b0, 1'b1, 8'hAA, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("flush_first_a", 32'(obus_a), 32'(8'hAA));
    chk("flush_first_b", 32'(obus_b), 32'(8'hAA));

    // Thresholds: fill to 3, raise the almost-full level mid-cycle.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 8'(8'h31 + i), 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge ff_clk);
    #1;
    chk("thr_alf_at3", 32'(alf_a), 32'(1));
    ff_thf = 3'd4;
    #1;
    chk("thr_alf_drop", 32'(alf_a), 32'(0));
    chk("thr_ale_at3", 32'(ale_a), 32'(0));
    ff_thf = 3'd3;
    step(1'b1, 1'b0, 1'b1, 8'h34, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

    // Random traffic with occasional flushes and threshold changes.
    for (int i = 0; i < 400; i++) begin
      if ((i % 32) == 0) begin
        ff_thf = 3'($urandom_range(0, 7));
        ff_the = 3'($urandom_range(0, 7));
      end
      step(1'b1, ($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)),
           8'($urandom), 1'($urandom_range(0, 1)));
    end
    ff_thf = 3'd3;
    ff_the = 3'd1;

    // Mid-operation reset with two entries held.
    guard = 0;
    while ((qa.size() > 0 || qb.size() > 0) && guard < 20) begin
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      guard++;
    end
    step(1'b1, 1'b0, 1'b1, 8'h81, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'h82, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("pre_rst_cnt", 32'(ocnt_a), 32'(2));
    chk("pre_rst_vld", 32'(ovld_a), 32'(1));
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("rst_vld", 32'(ovld_a), 32'(0));
    chk("rst_cnt", 32'(ocnt_a), 32'(0));
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("post_rst_vld_a", 32'(ovld_a), 32'(0));
    chk("post_rst_vld_b", 32'(ovld_b), 32'(0));
    step(1'b1, 1'b0, 1'b1, 8'h99, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("post_rst_first_a", 32'(obus_a), 32'(8'h99));
    chk("post_rst_first_b", 32'(obus_b), 32'(8'h99));
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
